// File: rtl/exc_pkg.sv
// Shared types and cause codes for the exception request controller.
// Imported by exc_prio_enc and exc_request.
package exc_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        HANDLER = 2'd2
    } exc_state_t;

    localparam logic [3:0] EXC_NONE     = 4'h0;
    localparam logic [3:0] EXC_INVOP    = 4'h1;
    localparam logic [3:0] EXC_IRQ_BASE = 4'h2;
    localparam logic [3:0] EXC_TIMER    = 4'hE;

endpackage

// File: rtl/exc_prio_enc.sv
// Fixed-priority cause encoder: invalid opcode, timer, then irq 0..NSRC-1.
// sel indexes the packed cause vector {ext, tmr, inv}.
module exc_prio_enc
    import exc_pkg::*;
#(
    parameter int NSRC = 4
) (
    input  logic            pend_inv,
    input  logic            pend_tmr,
    input  logic [NSRC-1:0] pend_ext,
    input  logic [NSRC-1:0] irq_en,
    output logic            valid,
    output logic [3:0]      code,
    output logic [3:0]      sel
);

    always_comb begin
        valid = 1'b0;
        code  = EXC_NONE;
        sel   = 4'd0;
        // Walk from lowest to highest priority so the last hit wins.
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (pend_ext[i] && irq_en[i]) begin
                valid = 1'b1;
                code  = EXC_IRQ_BASE + 4'(i);
                sel   = 4'(i + 2);
            end
        end
        if (pend_tmr) begin
            valid = 1'b1;
            code  = EXC_TIMER;
            sel   = 4'd1;
        end
        if (pend_inv) begin
            valid = 1'b1;
            code  = EXC_INVOP;
            sel   = 4'd0;
        end
    end

endmodule

// File: rtl/exc_request.sv
// Exception request controller: pending capture, arbitration and handshake FSM.
// Optional periodic timer cause is built when EXC_TIMER_EN is defined.
module exc_request
    import exc_pkg::*;
#(
    parameter int NSRC         = 4,
    parameter int TIMER_PERIOD = 1000
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NSRC-1:0] irq_i,
    input  logic [NSRC-1:0] irq_en,
    input  logic            inv_op,
    input  logic            timer_en,
    input  logic            ExcAck,
    input  logic            ERet,
    output logic            Exc,
    output logic [3:0]      EStatus,
    output logic            InHandler,
    output logic [NSRC-1:0] pending
);

    localparam int NP = NSRC + 2;

    exc_state_t      state, state_n;
    logic [NSRC-1:0] irq_q;
    logic [NP-1:0]   pnd;
    logic [NP-1:0]   set;
    logic [NP-1:0]   clr;
    logic [3:0]      sel;
    logic [3:0]      enc_sel;
    logic [3:0]      enc_code;
    logic            enc_valid;
    logic            latch;
    logic            ack;
    logic            tmr_wrap;

`ifdef EXC_TIMER_EN
    logic [31:0] tcnt;

    assign tmr_wrap = timer_en && (tcnt == 32'(TIMER_PERIOD - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            tcnt <= 32'd0;
        end else if (timer_en) begin
            tcnt <= tmr_wrap ? 32'd0 : tcnt + 32'd1;
        end
    end
`else
    logic timer_unused;

    assign tmr_wrap     = 1'b0;
    assign timer_unused = timer_en ^ (TIMER_PERIOD == 0);
`endif

    assign set     = {irq_i & ~irq_q, tmr_wrap, inv_op};
    assign pending = pnd[NP-1:2];

    exc_prio_enc #(
        .NSRC(NSRC)
    ) u_enc (
        .pend_inv(pnd[0]),
        .pend_tmr(pnd[1]),
        .pend_ext(pnd[NP-1:2]),
        .irq_en  (irq_en),
        .valid   (enc_valid),
        .code    (enc_code),
        .sel     (enc_sel)
    );

    always_comb begin
        state_n = state;
        latch   = 1'b0;
        ack     = 1'b0;
        unique case (state)
            IDLE: begin
                if (enc_valid) begin
                    state_n = REQ;
                    latch   = 1'b1;
                end
            end
            REQ: begin
                if (ExcAck) begin
                    state_n = HANDLER;
                    ack     = 1'b1;
                end
            end
            HANDLER: begin
                if (ERet) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        clr = '0;
        for (int i = 0; i < NP; i++) begin
            if (ack && sel == 4'(i)) begin
                clr[i] = 1'b1;
            end
        end
    end

    // A new event in the ack cycle survives the clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            Exc       <= 1'b0;
            InHandler <= 1'b0;
            EStatus   <= EXC_NONE;
            sel       <= 4'd0;
            pnd       <= '0;
            irq_q     <= '0;
        end else begin
            state     <= state_n;
            Exc       <= (state_n == REQ);
            InHandler <= (state_n == HANDLER);
            pnd       <= (pnd & ~clr) | set;
            irq_q     <= irq_i;
            if (latch) begin
                EStatus <= enc_code;
                sel     <= enc_sel;
            end
        end
    end

endmodule

// File: tb/tb_exc_request.sv
// Directed self-checking bench for exc_request (NSRC=4, TIMER_PERIOD=8).
// Timer scenario follows the EXC_TIMER_EN build setting.
module tb_exc_request;

    logic       clk;
    logic       reset;
    logic [3:0] irq_i;
    logic [3:0] irq_en;
    logic       inv_op;
    logic       timer_en;
    logic       ExcAck;
    logic       ERet;
    logic       Exc;
    logic [3:0] EStatus;
    logic       InHandler;
    logic [3:0] pending;

    int compared = 0;
    int mismatched = 0;

    exc_request #(
        .NSRC        (4),
        .TIMER_PERIOD(8)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .irq_i    (irq_i),
        .irq_en   (irq_en),
        .inv_op   (inv_op),
        .timer_en (timer_en),
        .ExcAck   (ExcAck),
        .ERet     (ERet),
        .Exc      (Exc),
        .EStatus  (EStatus),
        .InHandler(InHandler),
        .pending  (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        bit seen;
        reset    = 1'b1;
        irq_i    = 4'b0000;
        irq_en   = 4'b1111;
        inv_op   = 1'b0;
        timer_en = 1'b0;
        ExcAck   = 1'b0;
        ERet     = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        chk("rst_exc", Exc, 0);
        chk("rst_estatus", EStatus, 4'h0);
        chk("rst_pending", pending, 4'b0000);
        chk("rst_inhandler", InHandler, 0);

        // irq 2 basic handshake
        irq_i = 4'b0100;
        tick();
        chk("s1_pend", pending, 4'b0100);
        chk("s1_exc_e1", Exc, 0);
        tick();
        chk("s1_exc_e2", Exc, 1);
        chk("s1_code", EStatus, 4'h4);
        ExcAck = 1'b1;
        tick();
        chk("s1_ack_exc", Exc, 0);
        chk("s1_ack_inh", InHandler, 1);
        chk("s1_ack_pend", pending, 4'b0000);
        tick();
        chk("s1_ack_hold_inh", InHandler, 1);
        chk("s1_ack_hold_exc", Exc, 0);
        ExcAck = 1'b0;
        ERet   = 1'b1;
        tick();
        ERet = 1'b0;
        chk("s1_ret_inh", InHandler, 0);
        chk("s1_ret_exc", Exc, 0);
        chk("s1_hold_code", EStatus, 4'h4);

        // inv_op beats irq 0
        irq_i  = 4'b0001;
        inv_op = 1'b1;
        tick();
        inv_op = 1'b0;
        chk("s2_pend", pending, 4'b0001);
        tick();
        chk("s2_exc", Exc, 1);
        chk("s2_code", EStatus, 4'h1);
        ExcAck = 1'b1;
        tick();
        ExcAck = 1'b0;
        chk("s2_ack_inh", InHandler, 1);
        chk("s2_ack_pend", pending, 4'b0001);
        ERet = 1'b1;
        tick();
        ERet = 1'b0;
        chk("s2_idle_exc", Exc, 0);
        tick();
        chk("s2_re_exc", Exc, 1);
        chk("s2_re_code", EStatus, 4'h2);
        ExcAck = 1'b1;
        tick();
        ExcAck = 1'b0;
        chk("s2_re_pend", pending, 4'b0000);
        ERet = 1'b1;
        tick();
        ERet = 1'b0;

        // masked irq 1 stays pending
        irq_en = 4'b1101;
        irq_i  = 4'b0011;
        tick();
        chk("s3_pend", pending, 4'b0010);
        tick();
        tick();
        chk("s3_masked_exc", Exc, 0);
        irq_en = 4'b1111;
        tick();
        chk("s3_unmask_exc", Exc, 1);
        chk("s3_code", EStatus, 4'h3);
        ExcAck = 1'b1;
        tick();
        ExcAck = 1'b0;
        chk("s3_ack_inh", InHandler, 1);

        // irq 3 during handler waits for return
        irq_i = 4'b1011;
        tick();
        chk("s4_pend", pending, 4'b1000);
        chk("s4_exc_h1", Exc, 0);
        tick();
        chk("s4_exc_h2", Exc, 0);
        ERet = 1'b1;
        tick();
        ERet = 1'b0;
        chk("s4_idle_exc", Exc, 0);
        tick();
        chk("s4_exc", Exc, 1);
        chk("s4_code", EStatus, 4'h5);
        ERet = 1'b1;
        tick();
        ERet = 1'b0;
        chk("s4_eret_req_exc", Exc, 1);
        chk("s4_eret_req_inh", InHandler, 0);

        // reset mid-request
        reset = 1'b1;
        irq_i = 4'b0000;
        tick();
        chk("s5_rst_exc", Exc, 0);
        chk("s5_rst_code", EStatus, 4'h0);
        chk("s5_rst_pend", pending, 4'b0000);
        reset = 1'b0;
        tick();
        irq_i = 4'b0100;
        tick();
        chk("s5_pend", pending, 4'b0100);
        chk("s5_exc_e1", Exc, 0);
        tick();
        chk("s5_exc", Exc, 1);
        chk("s5_code", EStatus, 4'h4);
        ExcAck = 1'b1;
        tick();
        ExcAck = 1'b0;
        ERet   = 1'b1;
        tick();
        ERet = 1'b0;

        // new inv_op in the ack cycle must not be lost
        inv_op = 1'b1;
        tick();
        inv_op = 1'b0;
        tick();
        chk("s6_exc", Exc, 1);
        chk("s6_code", EStatus, 4'h1);
        ExcAck = 1'b1;
        inv_op = 1'b1;
        tick();
        ExcAck = 1'b0;
        inv_op = 1'b0;
        chk("s6_ack_inh", InHandler, 1);
        ERet = 1'b1;
        tick();
        ERet = 1'b0;
        tick();
        chk("s6_re_exc", Exc, 1);
        chk("s6_re_code", EStatus, 4'h1);

        // timer cause from reset
        reset    = 1'b1;
        irq_i    = 4'b0000;
        timer_en = 1'b1;
        tick();
        reset = 1'b0;
`ifdef EXC_TIMER_EN
        for (int i = 0; i < 8; i++) tick();
        chk("tmr_exc_e8", Exc, 0);
        tick();
        chk("tmr_exc_e9", Exc, 1);
        chk("tmr_code", EStatus, 4'hE);
`else
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (Exc) seen = 1'b1;
        end
        chk("no_tmr_exc", seen, 0);
        chk("no_tmr_code", EStatus, 4'h0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
